reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL provide parameter ZERO_REG, default 1, register 0 hardwired to zero when 1.
REQ-004 SHALL provide parameter BYPASS, default 1, same-cycle write-to-read forwarding when 1.
REQ-005 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port RegWrite  input  1  primary write enable.
REQ-008 SHALL have ports wrAddr  input  ADDR_W and wrData  input  DATA_W  primary write address and data.
REQ-009 SHALL have port ExtWrite  input  1  extended write enable, for the upper result of multi-cycle ops.
REQ-010 SHALL have ports wrAddrExt  input  ADDR_W and wrDataExt  input  DATA_W  extended write address and data.
REQ-011 SHALL have ports rdAddrA/rdAddrB  input  ADDR_W and rdDataA/rdDataB  output  DATA_W  two independent read ports.
REQ-012 SHALL have ports busySet  input  1 and busyAddr  input  ADDR_W  to mark a register pending.
REQ-013 SHALL have ports busyA/busyB  output  1  pending flag of the register at rdAddrA/rdAddrB.
REQ-014 SHALL have port rout  output  DATA_W  registered copy of the last accepted primary write data.

Function
REQ-015 SHALL write wrData to reg[wrAddr] at the rising edge when RegWrite=1 and reset=0.
REQ-016 SHALL write wrDataExt to reg[wrAddrExt] at the rising edge when ExtWrite=1 and reset=0.
REQ-017 SHALL let the primary write win when both ports write the same address in the same cycle.
REQ-018 SHALL ignore writes to address 0 when ZERO_REG=1; reads of address 0 return 0 and busy flags for address 0 are always 0.
REQ-019 SHALL make reads combinational, with zero-cycle latency from address to data.
REQ-020 SHALL, when BYPASS=1 and reset=0, return the write data being written this cycle on a read whose address matches an enabled write; primary has priority over extended, and address 0 is never bypassed when ZERO_REG=1.
REQ-021 SHALL, when BYPASS=0, return the pre-edge stored contents on a same-cycle read/write collision.
REQ-022 SHALL maintain one busy bit per register: busySet=1 sets bit[busyAddr] at the edge, and an accepted write on either port clears its target bit at the edge.
REQ-023 SHALL let set win over clear when the same address is set and written in the same cycle.
REQ-024 SHALL drive busyA/busyB combinationally from the busy bits with no bypass, so a write-clear is visible the cycle after the edge.
REQ-025 SHALL update rout to wrData at the edge on every accepted primary write (address 0 excluded when ZERO_REG=1), and hold it on extended-only writes.

Reset
REQ-026 SHALL, on the first edge with reset=1, clear all registers, all busy bits and rout to 0.
REQ-027 SHALL give reset priority over all writes and busySet in the same cycle, and suppress bypass while reset=1.
REQ-028 SHALL make any write or busySet asserted mid-reset have no effect after reset is released.

Verification
REQ-029 SHALL pass this test: reset one cycle, then read A=5, B=31 -> rdDataA=rdDataB=0, busyA=busyB=0, rout=0.
REQ-030 SHALL pass this test: RegWrite=1 wrAddr=10 wrData=0x15, ExtWrite=1 wrAddrExt=11 wrDataExt=0x4D, with rdAddrA=10 and rdAddrB=11 in the same cycle -> bypass gives A=0x15, B=0x4D; the next cycle holds the same values from storage and rout=0x15.
REQ-031 SHALL pass this test: both ports write address 15 (0x03, 0x69) in one cycle -> reg15=0x03.
REQ-032 SHALL pass this test: write 0xFFFF to address 0 -> reads of address 0 return 0 and rout stays unchanged.
REQ-033 SHALL pass this test: busySet address 7, then rdAddrA=7 gives busyA=1; a primary write to 7 gives busyA=0 the next cycle; set and write of 7 in the same cycle leaves busyA=1.
REQ-034 SHALL pass this test: reset asserted together with RegWrite to address 3 = 0xAB -> reg3=0 and rout=0 after reset.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with a primary and an extended write
// port, two combinational read ports, per-register pending (busy) flags and a
// registered copy of the last accepted primary write data.
//
// Ports
//   clk, reset             : rising-edge clock, synchronous active-high reset
//   RegWrite/wrAddr/wrData : primary write port
//   ExtWrite/wrAddrExt/wrDataExt : extended write port (upper result of
//                            multi-cycle ops); loses to primary on collision
//   rdAddrA/rdDataA, rdAddrB/rdDataB : combinational read ports
//   busySet/busyAddr       : mark a register pending
//   busyA/busyB            : pending flag of the register being read
//   rout                   : last accepted primary write data
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              ExtWrite,
    input  logic [ADDR_W-1:0] wrAddrExt,
    input  logic [DATA_W-1:0] wrDataExt,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0] rdDataA,
    output logic [DATA_W-1:0] rdDataB,
    input  logic              busySet,
    input  logic [ADDR_W-1:0] busyAddr,
    output logic              busyA,
    output logic              busyB,
    output logic [DATA_W-1:0] rout
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] rout_q, rout_d;
    logic              wr_ok, ext_ok, set_ok;

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // A write is "accepted" only if it targets a writable register.
    assign wr_ok  = RegWrite && !is_zero(wrAddr);
    assign ext_ok = ExtWrite && !is_zero(wrAddrExt);
    assign set_ok = busySet && !is_zero(busyAddr);

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        rout_d = rout_q;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs_d[i] = '0;
            busy_d = '0;
            rout_d = '0;
        end else begin
            // Extended first so the primary write overrides on the same address.
            if (ext_ok) begin
                regs_d[wrAddrExt] = wrDataExt;
                busy_d[wrAddrExt] = 1'b0;
            end
            if (wr_ok) begin
                regs_d[wrAddr] = wrData;
                busy_d[wrAddr] = 1'b0;
                rout_d         = wrData;
            end
            // Set after clear so a new pending op wins over a retiring write.
            if (set_ok) busy_d[busyAddr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        busy_q <= busy_d;
        rout_q <= rout_d;
    end

    assign rd_addr[0] = rdAddrA;
    assign rd_addr[1] = rdAddrB;

    // Reads: forward in-flight write data (primary before extended) unless in
    // reset; busy flags are never forwarded, so a clear shows up next cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
            if (is_zero(rd_addr[p])) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end else if ((BYPASS != 0) && !reset) begin
                if (wr_ok && (rd_addr[p] == wrAddr))
                    rd_data[p] = wrData;
                else if (ext_ok && (rd_addr[p] == wrAddrExt))
                    rd_data[p] = wrDataExt;
            end
        end
    end

    assign rdDataA = rd_data[0];
    assign rdDataB = rd_data[1];
    assign busyA   = rd_busy[0];
    assign busyB   = rd_busy[1];
    assign rout    = rout_q;

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite, ExtWrite, busySet;
    logic [4:0]  wrAddr, wrAddrExt, rdAddrA, rdAddrB, busyAddr;
    logic [31:0] wrData, wrDataExt, rdDataA, rdDataB, rout;
    logic        busyA, busyB;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ba;
        logic        bb;
        logic [31:0] r;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: plain arrays updated by the rules of the register file.
    logic [31:0] mem [32];
    bit          pend [32];
    logic [31:0] m_rout;

    reg_file_mp dut (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .wrAddr(wrAddr), .wrData(wrData),
        .ExtWrite(ExtWrite), .wrAddrExt(wrAddrExt), .wrDataExt(wrDataExt),
        .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .rdDataA(rdDataA), .rdDataB(rdDataB),
        .busySet(busySet), .busyAddr(busyAddr), .busyA(busyA), .busyB(busyB),
        .rout(rout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (!reset && RegWrite && wrAddr != 0 && wrAddr == a) return wrData;
        if (!reset && ExtWrite && wrAddrExt != 0 && wrAddrExt == a) return wrDataExt;
        return mem[a];
    endfunction

    // Drive one cycle's inputs; optionally record the expected outputs.
    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic xe, input logic [4:0] xa,
                         input logic [31:0] xd, input logic bs, input logic [4:0] ba,
                         input logic [4:0] ra, input logic [4:0] rb, input bit push);
        exp_t e;
        reset = rst; RegWrite = we; wrAddr = wa; wrData = wd;
        ExtWrite = xe; wrAddrExt = xa; wrDataExt = xd;
        busySet = bs; busyAddr = ba; rdAddrA = ra; rdAddrB = rb;
        if (push) begin
            e.a  = model_read(ra);
            e.b  = model_read(rb);
            e.ba = (ra == 0) ? 1'b0 : pend[ra];
            e.bb = (rb == 0) ? 1'b0 : pend[rb];
            e.r  = m_rout;
            exp_q.push_back(e);
        end
    endtask

    // Clock edge, then advance the model with the inputs that were applied.
    task automatic finish_cycle();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin mem[i] = 0; pend[i] = 0; end
            m_rout = 0;
        end else begin
            if (ExtWrite && wrAddrExt != 0) begin mem[wrAddrExt] = wrDataExt; pend[wrAddrExt] = 0; end
            if (RegWrite && wrAddr != 0) begin mem[wrAddr] = wrData; pend[wrAddr] = 0; m_rout = wrData; end
            if (busySet && busyAddr != 0) pend[busyAddr] = 1;
        end
        #1;
    endtask

    task automatic idle_read(input logic [4:0] ra, input logic [4:0] rb);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, ra, rb, 1);
    endtask

    // Monitor: outputs are combinational/registered and always presented, so
    // one expected entry is retired every cycle that has one queued.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rdDataA", rdDataA, e.a);
            chk("rdDataB", rdDataB, e.b);
            chk("busyA", {31'b0, busyA}, {31'b0, e.ba});
            chk("busyB", {31'b0, busyB}, {31'b0, e.bb});
            chk("rout", rout, e.r);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin mem[i] = 'x; pend[i] = 0; end
        m_rout = 'x;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // Reset one cycle (state unknown beforehand, so not scoreboarded).
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 31, 0);
        finish_cycle();
        idle_read(5, 31);
        #2;
        chk("rst_a", rdDataA, 32'h0); chk("rst_b", rdDataB, 32'h0);
        chk("rst_busy", {30'b0, busyA, busyB}, 32'h0); chk("rst_rout", rout, 32'h0);
        finish_cycle();

        // Dual write with same-cycle bypass, then stored values.
        drive(0, 1, 10, 32'h15, 1, 11, 32'h4D, 0, 0, 10, 11, 1);
        #2; chk("byp_a", rdDataA, 32'h15); chk("byp_b", rdDataB, 32'h4D);
        finish_cycle();
        idle_read(10, 11);
        #2; chk("st_a", rdDataA, 32'h15); chk("st_b", rdDataB, 32'h4D); chk("st_rout", rout, 32'h15);
        finish_cycle();

        // Both ports to address 15: primary wins.
        drive(0, 1, 15, 32'h03, 1, 15, 32'h69, 0, 0, 15, 15, 1);
        #2; chk("coll_byp", rdDataA, 32'h03);
        finish_cycle();
        idle_read(15, 0);
        #2; chk("coll_reg15", rdDataA, 32'h03);
        finish_cycle();

        // Write to address 0 is ignored.
        drive(0, 1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0, 1);
        #2; chk("zero_byp", rdDataA, 32'h0);
        finish_cycle();
        idle_read(0, 0);
        #2; chk("zero_rd", rdDataB, 32'h0); chk("zero_rout", rout, 32'h03);
        finish_cycle();

        // Busy flag set / clear / set-wins.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 7, 1);
        #2; chk("busy_not_byp", {31'b0, busyA}, 32'h0);
        finish_cycle();
        idle_read(7, 0);
        #2; chk("busy_set", {31'b0, busyA}, 32'h1);
        finish_cycle();
        drive(0, 1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0, 1);
        #2; chk("busy_hold", {31'b0, busyA}, 32'h1);
        finish_cycle();
        idle_read(7, 0);
        #2; chk("busy_clr", {31'b0, busyA}, 32'h0);
        finish_cycle();
        drive(0, 1, 7, 32'h78, 0, 0, 0, 1, 7, 7, 0, 1);
        finish_cycle();
        idle_read(7, 0);
        #2; chk("busy_setwin", {31'b0, busyA}, 32'h1);
        finish_cycle();

        // Extended write to a busy register also clears it; rout unchanged.
        drive(0, 0, 0, 0, 1, 7, 32'h99, 0, 0, 7, 7, 1);
        finish_cycle();
        idle_read(7, 7);
        #2; chk("ext_clr", {31'b0, busyB}, 32'h0); chk("ext_rout", rout, 32'h78);
        finish_cycle();

        // Reset together with a write: write is discarded, no bypass.
        drive(1, 1, 3, 32'hAB, 1, 4, 32'hCD, 1, 3, 3, 4, 1);
        #2; chk("rst_nobyp", rdDataA, 32'h0);
        finish_cycle();
        idle_read(3, 4);
        #2; chk("rst_reg3", rdDataA, 32'h0); chk("rst_rout2", rout, 32'h0);
        chk("rst_busy3", {31'b0, busyA}, 32'h0);
        finish_cycle();

        // Randomized traffic; half the addresses confined to 0..7 to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] a[5];
            for (int k = 0; k < 5; k++)
                a[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), a[0], $urandom(),
                  ($urandom_range(0, 2) == 0), a[1], $urandom(),
                  ($urandom_range(0, 3) == 0), a[2], a[3], a[4], 1);
            finish_cycle();
        end

        idle_read(1, 2);
        finish_cycle();
        repeat (2) @(posedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
